// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard sources in, pipeline
// register controls and status out.
interface hazard_ctrl_if;
    logic [4:0]  id_rs1_addr_i;
    logic        id_rs1_used_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs2_used_i;
    logic        ex_reg_write_i;
    logic [4:0]  ex_reg_write_data_addr_i;
    logic [1:0]  ex_reg_src_i;
    logic        branch_taken_i;
    logic        dmem_req_i;
    logic        dmem_ready_i;
    logic        pc_stall_o;
    logic        if_id_stall_o;
    logic        if_id_flush_o;
    logic        id_ex_stall_o;
    logic        id_ex_bubble_o;
    logic        ex_mem_stall_o;
    logic        mem_wb_bubble_o;
    logic [1:0]  state_o;
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;
    logic        mem_timeout_o;

    modport master (
        output id_rs1_addr_i, id_rs1_used_i,
        output id_rs2_addr_i, id_rs2_used_i,
        output ex_reg_write_i, ex_reg_write_data_addr_i,
        output ex_reg_src_i,
        output branch_taken_i, dmem_req_i, dmem_ready_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o,
        input  id_ex_stall_o, id_ex_bubble_o,
        input  ex_mem_stall_o, mem_wb_bubble_o,
        input  state_o, stall_cycles_o,
        input  flush_count_o, mem_timeout_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs1_used_i,
        input  id_rs2_addr_i, id_rs2_used_i,
        input  ex_reg_write_i, ex_reg_write_data_addr_i,
        input  ex_reg_src_i,
        input  branch_taken_i, dmem_req_i, dmem_ready_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o,
        output id_ex_stall_o, id_ex_bubble_o,
        output ex_mem_stall_o, mem_wb_bubble_o,
        output state_o, stall_cycles_o,
        output flush_count_o, mem_timeout_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, branch flush and
// load-use stall, with init sequencing and event counters.
module hazard_ctrl (
    input  logic          clk,
    input  logic          rst_i,
    hazard_ctrl_if.slave  bus
);
    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] MEM_WAIT = 2'b01;
    localparam logic [1:0] INIT     = 2'b10;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [1:0]  init_cnt_q;
    logic [31:0] stall_q;
    logic [15:0] flush_q;
    logic [7:0]  wait_q;
    logic [7:0]  wait_d;
    logic        tmo_q;

    logic is_init;
    logic in_wait;
    logic mem_hold;
    logic freeze;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic take_branch;
    logic take_lu;

    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_bubble;
    logic ex_mem_stall;
    logic mem_wb_bubble;

    assign is_init  = (state_q == INIT);
    assign in_wait  = (state_q == MEM_WAIT);
    assign mem_hold = bus.dmem_req_i & ~bus.dmem_ready_i;

    // Once waiting, only the ready strobe releases the freeze.
    assign freeze = in_wait ? ~bus.dmem_ready_i : mem_hold;

    assign rs1_hit = bus.id_rs1_used_i &
        (bus.id_rs1_addr_i == bus.ex_reg_write_data_addr_i);
    assign rs2_hit = bus.id_rs2_used_i &
        (bus.id_rs2_addr_i == bus.ex_reg_write_data_addr_i);

    assign load_use = bus.ex_reg_write_i &
        (bus.ex_reg_src_i == 2'b01) &
        (bus.ex_reg_write_data_addr_i != 5'd0) &
        (rs1_hit | rs2_hit);

    assign take_branch = ~rst_i & ~is_init & ~freeze &
        bus.branch_taken_i;
    assign take_lu = ~rst_i & ~is_init & ~freeze &
        ~bus.branch_taken_i & load_use;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // 2'b11 falls to the default arm and behaves as RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT: begin
                if (init_cnt_q == 2'd1) begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = mem_hold ? MEM_WAIT : RUN;
            end
        endcase
    end

    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        priority case (1'b1)
            rst_i: begin
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
                mem_wb_bubble = 1'b1;
            end
            is_init: begin
                pc_stall     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            freeze: begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_stall  = 1'b1;
                mem_wb_bubble = 1'b1;
            end
            take_branch: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            take_lu: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        wait_d = 8'd0;
        if (in_wait) begin
            wait_d = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            init_cnt_q <= 2'd0;
            stall_q    <= 32'd0;
            flush_q    <= 16'd0;
            wait_q     <= 8'd0;
            tmo_q      <= 1'b0;
        end else begin
            init_cnt_q <= is_init ? init_cnt_q + 2'd1 : 2'd0;
            if (pc_stall && !is_init) begin
                stall_q <= stall_q + 32'd1;
            end
            if (take_branch && flush_q != 16'hFFFF) begin
                flush_q <= flush_q + 16'd1;
            end
            wait_q <= wait_d;
            if (in_wait && wait_d == 8'hFF) begin
                tmo_q <= 1'b1;
            end
        end
    end

    assign bus.pc_stall_o      = pc_stall;
    assign bus.if_id_stall_o   = if_id_stall;
    assign bus.if_id_flush_o   = if_id_flush;
    assign bus.id_ex_stall_o   = id_ex_stall;
    assign bus.id_ex_bubble_o  = id_ex_bubble;
    assign bus.ex_mem_stall_o  = ex_mem_stall;
    assign bus.mem_wb_bubble_o = mem_wb_bubble;
    assign bus.state_o         = state_q;
    assign bus.stall_cycles_o  = stall_q;
    assign bus.flush_count_o   = flush_q;
    assign bus.mem_timeout_o   = tmo_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: cycle-level reference model plus directed
// scenarios with hand-computed expectations.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_if hif ();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (hif)
    );

    always #5 clk = ~clk;

    // Control vector: {pc, if_id_st, if_id_fl, id_ex_st,
    //                  id_ex_bub, ex_mem_st, mem_wb_bub}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_RST    = 7'b0010101;
    localparam logic [6:0] C_INIT   = 7'b1010100;
    localparam logic [6:0] C_FREEZE = 7'b1101011;
    localparam logic [6:0] C_BRANCH = 7'b0010100;
    localparam logic [6:0] C_LU     = 7'b1100100;

    int          m_age;
    bit          m_wait;
    int          m_wrun;
    int unsigned m_stalls;
    int          m_flush;
    bit          m_tmo;
    bit          started = 1'b0;

    function automatic logic [6:0] dut_ctl();
        return {hif.pc_stall_o, hif.if_id_stall_o,
                hif.if_id_flush_o, hif.id_ex_stall_o,
                hif.id_ex_bubble_o, hif.ex_mem_stall_o,
                hif.mem_wb_bubble_o};
    endfunction

    function automatic bit m_loaduse();
        bit hit;
        hit = (hif.id_rs1_used_i &&
               hif.id_rs1_addr_i == hif.ex_reg_write_data_addr_i) ||
              (hif.id_rs2_used_i &&
               hif.id_rs2_addr_i == hif.ex_reg_write_data_addr_i);
        return hif.ex_reg_write_i && hif.ex_reg_src_i == 2'b01 &&
               hif.ex_reg_write_data_addr_i != 0 && hit;
    endfunction

    function automatic logic [6:0] model_ctl();
        bit hold;
        if (rst_i) return C_RST;
        if (m_age < 2) return C_INIT;
        hold = m_wait ? !hif.dmem_ready_i
                      : (hif.dmem_req_i && !hif.dmem_ready_i);
        if (hold) return C_FREEZE;
        if (hif.branch_taken_i) return C_BRANCH;
        if (m_loaduse()) return C_LU;
        return C_NONE;
    endfunction

    function automatic logic [1:0] model_state();
        if (m_age < 2) return 2'b10;
        return m_wait ? 2'b01 : 2'b00;
    endfunction

    always @(posedge clk) begin
        logic [6:0] c;
        started <= 1'b1;
        c = model_ctl();
        if (rst_i) begin
            m_age = 0; m_wait = 0; m_wrun = 0;
            m_stalls = 0; m_flush = 0; m_tmo = 0;
        end else if (m_age < 2) begin
            m_age = m_age + 1;
        end else begin
            if (c[6]) m_stalls = m_stalls + 1;
            if (c == C_BRANCH && m_flush < 65535)
                m_flush = m_flush + 1;
            if (m_wait) begin
                m_wrun = m_wrun + 1;
                if (m_wrun >= 255) m_tmo = 1;
                m_wait = !hif.dmem_ready_i;
            end else begin
                m_wrun = 0;
                m_wait = (c == C_FREEZE);
            end
        end
    end

    always @(negedge clk) begin
        logic [57:0] act, exp;
        if (started) begin
            act = {dut_ctl(), hif.state_o, hif.stall_cycles_o,
                   hif.flush_count_o, hif.mem_timeout_o};
            exp = {model_ctl(), model_state(), m_stalls,
                   16'(m_flush), m_tmo};
            checks = checks + 1;
            if (act !== exp) begin
                errors = errors + 1;
                $display("FAIL model t=%0t got %h want %h",
                         $time, act, exp);
            end
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        hif.id_rs1_addr_i = 5'd0;
        hif.id_rs1_used_i = 1'b0;
        hif.id_rs2_addr_i = 5'd0;
        hif.id_rs2_used_i = 1'b0;
        hif.ex_reg_write_i = 1'b0;
        hif.ex_reg_write_data_addr_i = 5'd0;
        hif.ex_reg_src_i = 2'b00;
        hif.branch_taken_i = 1'b0;
        hif.dmem_req_i = 1'b0;
        hif.dmem_ready_i = 1'b0;
    endtask

    task automatic load_to(input logic [4:0] rd,
                           input logic [4:0] rs2);
        hif.ex_reg_write_i = 1'b1;
        hif.ex_reg_src_i = 2'b01;
        hif.ex_reg_write_data_addr_i = rd;
        hif.id_rs2_addr_i = rs2;
        hif.id_rs2_used_i = 1'b1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_i = 1'b1;
        adv();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("rst_ctl", 32'(dut_ctl()), 32'(C_RST));
            adv();
        end
        rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("init_state", 32'(hif.state_o), 32'h2);
            chk("init_ctl", 32'(dut_ctl()), 32'(C_INIT));
            adv();
        end
        sample();
        chk("run_state", 32'(hif.state_o), 32'h0);
        chk("run_ctl", 32'(dut_ctl()), 32'(C_NONE));
        adv();

        load_to(5'd5, 5'd5);
        sample();
        chk("lu_ctl", 32'(dut_ctl()), 32'(C_LU));
        adv();
        idle();
        sample();
        chk("lu_cnt", hif.stall_cycles_o, 32'd1);
        adv();
        load_to(5'd0, 5'd0);
        sample();
        chk("lu_x0", 32'(dut_ctl()), 32'(C_NONE));
        adv();
        load_to(5'd7, 5'd3);
        hif.id_rs1_addr_i = 5'd7;
        sample();
        chk("lu_rs1_unused", 32'(dut_ctl()), 32'(C_NONE));
        adv();

        load_to(5'd5, 5'd5);
        hif.branch_taken_i = 1'b1;
        sample();
        chk("br_over_lu", 32'(dut_ctl()), 32'(C_BRANCH));
        adv();
        idle();
        sample();
        chk("br_cnt", 32'(hif.flush_count_o), 32'd1);
        chk("br_stall_cnt", hif.stall_cycles_o, 32'd1);
        adv();

        hif.dmem_req_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            sample();
            chk("frz_ctl", 32'(dut_ctl()), 32'(C_FREEZE));
            chk("frz_state", 32'(hif.state_o),
                (i == 1) ? 32'h0 : 32'h1);
            adv();
        end
        hif.dmem_ready_i = 1'b1;
        sample();
        chk("rel_ctl", 32'(dut_ctl()), 32'(C_NONE));
        adv();
        idle();
        sample();
        chk("rel_state", 32'(hif.state_o), 32'h0);
        chk("frz_cnt", hif.stall_cycles_o, 32'd5);
        adv();

        hif.dmem_req_i = 1'b1;
        hif.branch_taken_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("pend_frz", 32'(dut_ctl()), 32'(C_FREEZE));
            adv();
        end
        hif.dmem_ready_i = 1'b1;
        sample();
        chk("pend_br", 32'(dut_ctl()), 32'(C_BRANCH));
        adv();
        idle();
        sample();
        chk("pend_cnt", 32'(hif.flush_count_o), 32'd2);
        adv();

        hif.dmem_req_i = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            sample();
            if (i == 256) chk("tmo_early", 32'(hif.mem_timeout_o), 0);
            if (i == 257) chk("tmo_set", 32'(hif.mem_timeout_o), 1);
            adv();
        end
        hif.dmem_ready_i = 1'b1;
        sample();
        adv();
        idle();
        sample();
        chk("tmo_sticky", 32'(hif.mem_timeout_o), 32'd1);
        chk("tmo_stalls", hif.stall_cycles_o, 32'd307);
        chk("model_stalls", m_stalls, 32'd307);
        adv();

        hif.dmem_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            adv();
        end
        rst_i = 1'b1;
        sample();
        chk("rst_wait_ctl", 32'(dut_ctl()), 32'(C_RST));
        adv();
        rst_i = 1'b0;
        sample();
        chk("rst_wait_state", 32'(hif.state_o), 32'h2);
        chk("rst_wait_ctl2", 32'(dut_ctl()), 32'(C_INIT));
        chk("rst_wait_tmo", 32'(hif.mem_timeout_o), 32'd0);
        chk("rst_wait_stall", hif.stall_cycles_o, 32'd0);
        adv();
        idle();
        for (int i = 0; i < 3; i++) begin
            sample();
            adv();
        end
        sample();
        chk("final_state", 32'(hif.state_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, system clock (all state updates on posedge); rst_i in 1, reset, synchronous, active-high.
REQ-002 SHALL have inputs id_rs1_addr_i [4:0], id_rs1_used_i 1, id_rs2_addr_i [4:0], id_rs2_used_i 1: source registers of the instruction in ID.
REQ-003 SHALL have inputs ex_reg_write_i 1, ex_reg_write_data_addr_i [4:0], ex_reg_src_i [1:0]: ID/EX register outputs of the instruction in EX; ex_reg_src_i==2'b01 means load.
REQ-004 SHALL have inputs branch_taken_i 1 (EX redirects PC), dmem_req_i 1 (MEM stage accesses data memory), dmem_ready_i 1 (data memory completes this cycle).
REQ-005 SHALL have outputs pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_bubble_o, ex_mem_stall_o, mem_wb_bubble_o, each 1 bit.
REQ-006 SHALL have outputs state_o [1:0], stall_cycles_o [31:0], flush_count_o [15:0], mem_timeout_o 1.

Function
REQ-007 SHALL implement FSM: INIT=2'b10, RUN=2'b00, MEM_WAIT=2'b01; state_o = current state; 2'b11 unreachable, treated as RUN.
REQ-008 SHALL stay in INIT exactly 2 cycles after rst_i falls (2-bit init counter), then enter RUN; in INIT: pc_stall_o=1, if_id_flush_o=1, id_ex_bubble_o=1, others 0.
REQ-009 SHALL compute control outputs combinationally (Mealy) from state and current inputs; state/counters registered.
REQ-010 SHALL, in RUN, define mem_hold = dmem_req_i & ~dmem_ready_i; load_use = ex_reg_write_i & ex_reg_src_i==2'b01 & ex_reg_write_data_addr_i!=0 & ((id_rs1_used_i & rs1 match) | (id_rs2_used_i & rs2 match)).
REQ-011 SHALL prioritise mem_hold > branch_taken_i > load_use; lower-priority events are ignored that cycle.
REQ-012 SHALL, on mem_hold (RUN or MEM_WAIT): assert pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_bubble_o; all flush/other bubble outputs 0.
REQ-013 SHALL transition RUN->MEM_WAIT on mem_hold; MEM_WAIT->RUN in the cycle dmem_ready_i=1 (freeze released that same cycle, no stall outputs).
REQ-014 SHALL, on branch_taken_i (no mem_hold): if_id_flush_o=1, id_ex_bubble_o=1, no stalls; single cycle; flush_count_o +1, saturating at 16'hFFFF.
REQ-015 SHALL, on load_use (no higher event): pc_stall_o=1, if_id_stall_o=1, id_ex_bubble_o=1 for exactly one cycle (load advances, condition clears).
REQ-016 SHALL never assert x_stall and the same register's flush/bubble together; stall wins by REQ-011 ordering.
REQ-017 SHALL increment stall_cycles_o every cycle pc_stall_o=1 in RUN/MEM_WAIT (not INIT), wrapping at 2^32.
REQ-018 SHALL count consecutive MEM_WAIT cycles in an 8-bit wait counter (cleared on leaving MEM_WAIT); when it reaches 255, set mem_timeout_o sticky; freeze continues.
REQ-019 SHALL keep branch_taken_i arriving during freeze pending in EX (frozen), acted on the cycle freeze releases.

Reset
REQ-020 SHALL, while rst_i=1 at posedge: state<=INIT, init counter<=0, stall_cycles_o<=0, flush_count_o<=0, wait counter<=0, mem_timeout_o<=0.
REQ-021 SHALL drive during rst_i=1: if_id_flush_o=1, id_ex_bubble_o=1, mem_wb_bubble_o=1, all stall outputs 0.
REQ-022 SHALL honour reset mid-MEM_WAIT: next cycle state=INIT, freeze dropped, counters zeroed.

Verification
REQ-023 SHALL cover: reset 3 cycles, release -> 2 cycles state_o=2'b10 with flush/bubble high, 3rd cycle state_o=2'b00, all outputs 0.
REQ-024 SHALL cover: EX load to x5, ID uses rs2=x5 -> one cycle pc_stall/if_id_stall/id_ex_bubble=1, stall_cycles_o=1; same with x0 -> no stall.
REQ-025 SHALL cover: dmem_req_i=1, dmem_ready_i=0 for 4 cycles then 1 -> 4 freeze cycles, state_o=01 for 3, release on ready cycle, stall_cycles_o=4.
REQ-026 SHALL cover: branch_taken_i with simultaneous load_use -> flush+bubble only, no pc_stall, flush_count_o=1.
REQ-027 SHALL cover: ready held 0 for 300 cycles -> mem_timeout_o=1 from 256th wait cycle, stays 1 after ready; cleared only by rst_i.
